// File: rtl/ks_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with carry-in folded in as a generate at position -1.
// Per-stage valid/ready flow control lets bubbles collapse while the output is stalled.
module ks_adder_pipe #(
    parameter int WIDTH       = 16,
    parameter int PIPE_LEVELS = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf
);

    localparam int LEVELS  = $clog2(WIDTH);
    localparam int LATENCY = (PIPE_LEVELS == 0) ? 2 : LEVELS + 2;
    // Registered prefix stages between the input register (stage 0) and the output register.
    localparam int NMID    = LATENCY - 2;

    // One Kogge-Stone level: node j absorbs node j-span; nodes below span pass through.
    function automatic logic [2*WIDTH-1:0] ks_level(input int span,
                                                     input logic [WIDTH-1:0] g,
                                                     input logic [WIDTH-1:0] p);
        logic [WIDTH-1:0] go;
        logic [WIDTH-1:0] po;
        int               lo;
        go = g;
        po = p;
        for (int j = 0; j < WIDTH; j++) begin
            if (j >= span) begin
                lo    = j - span;
                go[j] = g[j] | (p[j] & g[lo]);
                po[j] = p[j] & p[lo];
            end
        end
        return {go, po};
    endfunction

    // Applies the remaining levels first..LEVELS and returns the carry into each bit.
    function automatic logic [WIDTH-1:0] ks_carries(input int first,
                                                     input logic [WIDTH-1:0] g,
                                                     input logic [WIDTH-1:0] p);
        logic [WIDTH-1:0] gc;
        logic [WIDTH-1:0] pc;
        gc = g;
        pc = p;
        for (int k = first; k <= LEVELS; k++) begin
            {gc, pc} = ks_level(1 << (k - 1), gc, pc);
        end
        return gc;
    endfunction

    logic [WIDTH-1:0] beff;
    logic [WIDTH-1:0] g0;
    logic [WIDTH-1:0] p0;
    logic [WIDTH-1:0] node_g;
    logic [WIDTH-1:0] node_p;
    logic             c0;

    logic [WIDTH-1:0] gg_p [NMID+1];
    logic [WIDTH-1:0] pp_p [NMID+1];
    logic [WIDTH-1:0] bp_p [NMID+1];
    logic             gm_p [NMID+1];
    logic [NMID:0]    vld_p;
    logic [NMID+1:0]  ld;

    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] sum_c;
    logic             cout_c;
    logic             ovf_c;

    // Stage 0 input: node 0 carries c0, node j carries bit j-1.
    always_comb begin
        beff   = Sub ? ~B : B;
        c0     = Sub | Cin;
        p0     = A ^ beff;
        g0     = A & beff;
        node_g = {g0[WIDTH-2:0], c0};
        node_p = {p0[WIDTH-2:0], 1'b0};
    end

    always_comb begin
        logic acc;
        acc        = !out_valid || out_ready;
        ld         = '0;
        ld[NMID+1] = acc;
        for (int s = NMID; s >= 0; s--) begin
            acc   = acc | !vld_p[s];
            ld[s] = acc;
        end
    end

    assign in_ready = ld[0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p <= '0;
        end else begin
            if (ld[0]) vld_p[0] <= in_valid;
            for (int s = 1; s <= NMID; s++) begin
                if (ld[s]) vld_p[s] <= vld_p[s-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ld[0] && in_valid) begin
            gg_p[0] <= node_g;
            pp_p[0] <= node_p;
            bp_p[0] <= p0;
            gm_p[0] <= g0[WIDTH-1];
        end
        // Prefix stages: stage s holds the result of prefix level s.
        for (int s = 1; s <= NMID; s++) begin
            if (ld[s] && vld_p[s-1]) begin
                {gg_p[s], pp_p[s]} <= ks_level(1 << (s - 1), gg_p[s-1], pp_p[s-1]);
                bp_p[s]            <= bp_p[s-1];
                gm_p[s]            <= gm_p[s-1];
            end
        end
    end

    // Output stage: remaining prefix levels (all of them when unpipelined), then sum bits.
    always_comb begin
        carry  = ks_carries(NMID + 1, gg_p[NMID], pp_p[NMID]);
        sum_c  = bp_p[NMID] ^ carry;
        cout_c = gm_p[NMID] | (bp_p[NMID][WIDTH-1] & carry[WIDTH-1]);
        ovf_c  = carry[WIDTH-1] ^ cout_c;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            Sum       <= '0;
            Cout      <= 1'b0;
            Ovf       <= 1'b0;
        end else if (ld[NMID+1]) begin
            out_valid <= vld_p[NMID];
            if (vld_p[NMID]) begin
                Sum  <= sum_c;
                Cout <= cout_c;
                Ovf  <= ovf_c;
            end
        end
    end

endmodule
